fetch_decode_reg: RTL and testbench
===================================

# fetch_decode_reg

Instruction-fetch stage and IF/ID pipeline register. It owns the program counter, drives the instruction-memory address and captures the returned word. It presents the decode stage with the instruction, PC+4, the raw 16-bit immediate and the `Zero_Extend` control, which feed `Sign_Extend` directly. Stall, flush, redirect and halt handling live here so downstream stages see only clean valid/bubble slots.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset (word-aligned).
- `HALT_WORD`, 32'hFFFF_FFFF, instruction encoding that stops fetch.
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall_D`  in  1  hold PC and IF/ID contents.
- `flush_D`  in  1  replace the next IF/ID load with a bubble.
- `redirect_en`  in  1  load PC from `redirect_pc` (branch/jump taken).
- `redirect_pc`  in  32  redirect target; bits [1:0] forced to 0.
- `imem_addr`  out  32  instruction-memory address (= PC_F).
- `imem_rdata`  in  32  instruction word, combinational read of `imem_addr`.
- `instr_D`  out  32  registered instruction.
- `pc_plus4_D`  out  32  registered PC_F+4 of that instruction.
- `imm16_D`  out  16  `instr_D[15:0]`, goes to `Sign_Extend.In`.
- `zero_extend_D`  out  1  goes to `Sign_Extend.Zero_Extend`.
- `valid_D`  out  1  IF/ID slot holds a real instruction.
- `halted`  out  1  fetch is stopped on `HALT_WORD`.
- `instr_count`  out  32  number of valid instructions loaded into IF/ID.

## Operation
- FSM states: BOOT, RUN, HALTED. Reset enters BOOT.
- **BOOT** lasts one cycle.
  - No IF/ID load and no PC increment.
  - With `redirect_en`: PC_F<=redirect_pc. Either way, next state is RUN.
- **RUN**, PC_F next-state priority:
  - `redirect_en` -> `{redirect_pc[31:2],2'b00}`.
  - else `stall_D` -> hold.
  - else fetched word == HALT_WORD -> hold, and go to HALTED.
  - else PC_F+4. The addition is mod 2^32, so 32'hFFFF_FFFC wraps to 0.
- **RUN**, IF/ID next-state priority:
  - `flush_D` -> bubble (instr 0, pc_plus4 0, valid 0).
  - else `stall_D` -> hold.
  - else `redirect_en` or halt word fetched -> bubble.
  - else load `imem_rdata`, PC_F+4, valid 1.
- **HALTED**
  - PC_F holds; `halted`=1; IF/ID loads a bubble each cycle unless `stall_D` holds it.
  - `redirect_en` -> PC_F<=redirect_pc, state RUN, `halted`=0 next cycle.
- `HALT_WORD` is never forwarded as valid.
- `zero_extend_D` is registered alongside `instr_D`.
  - It is 1 iff valid and the opcode [31:26] ∈ {6'h0C ANDI, 6'h0D ORI, 6'h0E XORI}; otherwise 0.
  - A bubble gives 0.
- `instr_count` increments by 1 on every cycle IF/ID loads with valid 1, and wraps at 2^32.
- `redirect_en` with `stall_D` in the same cycle: PC redirects; IF/ID holds (the stalled instruction is kept).
- `flush_D` with `stall_D` in the same cycle: flush wins.

## Timing
- Reset (async assert, synchronous release):
  - PC_F=RESET_PC, so `imem_addr`=RESET_PC.
  - State BOOT.
  - All of these are 0: `instr_D`, `pc_plus4_D`, `imm16_D`, `zero_extend_D`, `valid_D`, `halted`, `instr_count`.
- First valid instruction appears at the IF/ID outputs after the 2nd rising edge following reset release (BOOT edge, then fetch edge).
- Fetch-to-decode latency is 1 cycle. Redirect penalty is 1 bubble, or 2 if `flush_D` is also asserted by the control unit.
- Reset asserted mid-operation: all state returns to reset values immediately, with no edge required.

## Test plan
- **Reset and sequential fetch:** release reset; imem returns word = address.
  - After 2 edges: `instr_D`=0, `pc_plus4_D`=4, `valid_D`=1.
  - After 3 edges: `instr_D`=4, `pc_plus4_D`=8.
  - `instr_count` increments each cycle.
- **Zero_Extend decode:**
  - Fetch 32'h3422_8000 (ORI) -> `imm16_D`=16'h8000, `zero_extend_D`=1.
  - Fetch 32'h2022_8000 (ADDI) -> `zero_extend_D`=0.
- **Stall and flush:**
  - Assert `stall_D` for 3 cycles at PC=8 -> `imem_addr` stays 8 and IF/ID is unchanged.
  - `stall_D`+`flush_D` together -> `valid_D`=0 next cycle.
- **Redirect:**
  - `redirect_en`=1, `redirect_pc`=32'h0000_0103 at PC=12 -> next `imem_addr`=32'h100, IF/ID bubble.
  - Then `instr_D`=word@0x100, `pc_plus4_D`=0x104.
- **Halt:**
  - imem returns 32'hFFFF_FFFF at PC=0x20 -> `halted`=1, `imem_addr` holds 0x20, `valid_D`=0 thereafter, `instr_count` frozen.
  - Redirect to 0x40 -> `halted`=0 and fetch resumes at 0x40.
- **Wrap and async reset:**
  - Redirect to 32'hFFFF_FFFC -> next PC=0 and `pc_plus4_D`=0.
  - Assert `rst_n`=0 mid-cycle -> all outputs take reset values without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_decode_reg.sv
// Instruction-fetch stage with IF/ID pipeline register: owns PC_F, captures the fetched
// word and hands decode a clean valid/bubble slot plus the Sign_Extend controls.
module fetch_decode_reg #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_D,
  input  logic        flush_D,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_D,
  output logic [31:0] pc_plus4_D,
  output logic [15:0] imm16_D,
  output logic        zero_extend_D,
  output logic        valid_D,
  output logic        halted,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {StBoot, StRun, StHalted} state_e;

  state_e      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;
  logic        r_ze;
  logic        r_halted;
  logic [31:0] r_count;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_redirect_pc;
  logic        w_halt_fetch;
  logic        w_ze_fetch;
  logic        w_if_load;
  logic        w_if_bubble;

  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_halt_fetch  = (imem_rdata == HALT_WORD);
  assign w_ze_fetch    = (imem_rdata[31:26] == 6'h0C) || (imem_rdata[31:26] == 6'h0D) ||
                         (imem_rdata[31:26] == 6'h0E);

  // IF/ID slot control: flush beats stall, stall beats everything else.
  always_comb begin
    w_if_load   = 1'b0;
    w_if_bubble = 1'b0;
    unique case (r_state)
      StRun: begin
        if (flush_D) begin
          w_if_bubble = 1'b1;
        end else if (!stall_D) begin
          if (redirect_en || w_halt_fetch) w_if_bubble = 1'b1;
          else                             w_if_load   = 1'b1;
        end
      end
      StHalted: w_if_bubble = flush_D || !stall_D;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StBoot;
      r_pc     <= RESET_PC;
      r_instr  <= 32'd0;
      r_pc4    <= 32'd0;
      r_valid  <= 1'b0;
      r_ze     <= 1'b0;
      r_halted <= 1'b0;
      r_count  <= 32'd0;
    end else begin
      unique case (r_state)
        StBoot: begin
          if (redirect_en) r_pc <= w_redirect_pc;
          r_state <= StRun;
        end
        StRun: begin
          if (redirect_en) begin
            r_pc <= w_redirect_pc;
          end else if (!stall_D) begin
            if (w_halt_fetch) begin
              r_state  <= StHalted;
              r_halted <= 1'b1;
            end else begin
              r_pc <= w_pc_plus4;
            end
          end
        end
        StHalted: begin
          if (redirect_en) begin
            r_pc     <= w_redirect_pc;
            r_state  <= StRun;
            r_halted <= 1'b0;
          end
        end
        default: r_state <= StBoot;
      endcase

      if (w_if_bubble) begin
        r_instr <= 32'd0;
        r_pc4   <= 32'd0;
        r_valid <= 1'b0;
        r_ze    <= 1'b0;
      end else if (w_if_load) begin
        r_instr <= imem_rdata;
        r_pc4   <= w_pc_plus4;
        r_valid <= 1'b1;
        r_ze    <= w_ze_fetch;
        r_count <= r_count + 32'd1;
      end
    end
  end

  assign imem_addr     = r_pc;
  assign instr_D       = r_instr;
  assign pc_plus4_D    = r_pc4;
  assign imm16_D       = r_instr[15:0];
  assign zero_extend_D = r_ze;
  assign valid_D       = r_valid;
  assign halted        = r_halted;
  assign instr_count   = r_count;

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Directed bench for fetch_decode_reg: a vector table walks fetch, stall, flush, redirect,
// halt and wrap; hand-written sequences cover async reset and redirect during BOOT.
module tb_fetch_decode_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_D = 1'b0;
  logic        flush_D = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_D;
  logic [31:0] pc_plus4_D;
  logic [15:0] imm16_D;
  logic        zero_extend_D;
  logic        valid_D;
  logic        halted;
  logic [31:0] instr_count;

  int checks = 0;
  int failures = 0;

  fetch_decode_reg dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_D       (stall_D),
    .flush_D       (flush_D),
    .redirect_en   (redirect_en),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .instr_D       (instr_D),
    .pc_plus4_D    (pc_plus4_D),
    .imm16_D       (imm16_D),
    .zero_extend_D (zero_extend_D),
    .valid_D       (valid_D),
    .halted        (halted),
    .instr_count   (instr_count)
  );

  always #5 clk = ~clk;

  // Instruction memory: word = address, except a few planted instructions.
  always_comb begin
    imem_rdata = imem_addr;
    case (imem_addr)
      32'h0000_0020: imem_rdata = 32'hFFFF_FFFF;
      32'h0000_0100: imem_rdata = 32'h3422_8000;
      32'h0000_0104: imem_rdata = 32'h2022_8000;
      default: ;
    endcase
  end

  typedef struct {
    logic        stall;
    logic        flush;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        ze;
    logic        hlt;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    logic [15:0] imm;
    imm = v.instr[15:0];
    chk({tag, " imem_addr"}, imem_addr, v.addr);
    chk({tag, " instr_D"}, instr_D, v.instr);
    chk({tag, " pc_plus4_D"}, pc_plus4_D, v.pc4);
    chk({tag, " imm16_D"}, {16'd0, imm16_D}, {16'd0, imm});
    chk({tag, " zero_extend_D"}, {31'd0, zero_extend_D}, {31'd0, v.ze});
    chk({tag, " valid_D"}, {31'd0, valid_D}, {31'd0, v.valid});
    chk({tag, " halted"}, {31'd0, halted}, {31'd0, v.hlt});
    chk({tag, " instr_count"}, instr_count, v.cnt);
  endtask

  function automatic vec_t mk(logic s, logic f, logic r, logic [31:0] rpc, logic [31:0] a,
                              logic [31:0] i, logic [31:0] p, logic v, logic z, logic h,
                              logic [31:0] c);
    vec_t t;
    t.stall = s; t.flush = f; t.redir = r; t.rpc = rpc; t.addr = a; t.instr = i;
    t.pc4 = p; t.valid = v; t.ze = z; t.hlt = h; t.cnt = c;
    return t;
  endfunction

  vec_t zero_v;

  initial begin
    //            stl flu red rpc            addr           instr          pc4            v  ze h cnt
    vecs[0]  = mk(0, 0, 0, 32'h0,          32'h0,         32'h0,         32'h0,         0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 32'h0,          32'h4,         32'h0,         32'h4,         1, 0, 0, 1);
    vecs[2]  = mk(0, 0, 0, 32'h0,          32'h8,         32'h4,         32'h8,         1, 0, 0, 2);
    vecs[3]  = mk(1, 0, 0, 32'h0,          32'h8,         32'h4,         32'h8,         1, 0, 0, 2);
    vecs[4]  = mk(1, 0, 0, 32'h0,          32'h8,         32'h4,         32'h8,         1, 0, 0, 2);
    vecs[5]  = mk(1, 0, 0, 32'h0,          32'h8,         32'h4,         32'h8,         1, 0, 0, 2);
    vecs[6]  = mk(0, 0, 0, 32'h0,          32'hC,         32'h8,         32'hC,         1, 0, 0, 3);
    vecs[7]  = mk(0, 0, 1, 32'h103,        32'h100,       32'h0,         32'h0,         0, 0, 0, 3);
    vecs[8]  = mk(0, 0, 0, 32'h0,          32'h104,       32'h3422_8000, 32'h104,       1, 1, 0, 4);
    vecs[9]  = mk(0, 0, 0, 32'h0,          32'h108,       32'h2022_8000, 32'h108,       1, 0, 0, 5);
    vecs[10] = mk(1, 1, 0, 32'h0,          32'h108,       32'h0,         32'h0,         0, 0, 0, 5);
    vecs[11] = mk(0, 0, 0, 32'h0,          32'h10C,       32'h108,       32'h10C,       1, 0, 0, 6);
    vecs[12] = mk(1, 0, 1, 32'h18,         32'h18,        32'h108,       32'h10C,       1, 0, 0, 6);
    vecs[13] = mk(0, 0, 0, 32'h0,          32'h1C,        32'h18,        32'h1C,        1, 0, 0, 7);
    vecs[14] = mk(0, 0, 0, 32'h0,          32'h20,        32'h1C,        32'h20,        1, 0, 0, 8);
    vecs[15] = mk(0, 0, 0, 32'h0,          32'h20,        32'h0,         32'h0,         0, 0, 1, 8);
    vecs[16] = mk(0, 0, 0, 32'h0,          32'h20,        32'h0,         32'h0,         0, 0, 1, 8);
    vecs[17] = mk(0, 0, 1, 32'h40,         32'h40,        32'h0,         32'h0,         0, 0, 0, 8);
    vecs[18] = mk(0, 0, 0, 32'h0,          32'h44,        32'h40,        32'h44,        1, 0, 0, 9);
    vecs[19] = mk(0, 0, 1, 32'hFFFF_FFFC,  32'hFFFF_FFFC, 32'h0,         32'h0,         0, 0, 0, 9);
    vecs[20] = mk(0, 0, 0, 32'h0,          32'h0,         32'hFFFF_FFFC, 32'h0,         1, 0, 0, 10);
    vecs[21] = mk(0, 1, 0, 32'h0,          32'h4,         32'h0,         32'h0,         0, 0, 0, 10);
    vecs[22] = mk(0, 0, 0, 32'h0,          32'h8,         32'h4,         32'h8,         1, 0, 0, 11);
    zero_v   = mk(0, 0, 0, 32'h0,          32'h0,         32'h0,         32'h0,         0, 0, 0, 0);

    #2;
    chk_all("reset", zero_v);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      stall_D = vecs[i].stall;
      flush_D = vecs[i].flush;
      redirect_en = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), vecs[i]);
    end
    stall_D = 1'b0; flush_D = 1'b0; redirect_en = 1'b0; redirect_pc = 32'd0;

    // Mid-cycle async reset: outputs clear with no clock edge.
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", zero_v);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Redirect during BOOT: PC loads target, no IF/ID load that cycle.
    redirect_en = 1'b1; redirect_pc = 32'h0000_0203;
    @(posedge clk); #1;
    redirect_en = 1'b0; redirect_pc = 32'd0;
    chk_all("boot_redirect", mk(0, 0, 0, 0, 32'h200, 32'h0, 32'h0, 0, 0, 0, 0));
    @(posedge clk); #1;
    chk_all("boot_redirect_fetch", mk(0, 0, 0, 0, 32'h204, 32'h200, 32'h204, 1, 0, 0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
